// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared ALU definitions for the nibble-serial ALU sequencer.
//   - Op encodings understood by the 4-bit slice and the sequencer.
//   - Op legality and arithmetic-class helpers.
//   - Sequencer state enum.
package alu_nibble_sequencer_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    // ADD, SUB and SLT all go through the adder; AND/OR do not.
    function automatic logic op_is_arith(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer_alu4bit.sv
// ALU4Bit: 4-bit combinational ALU slice with carry chaining.
// Ports:
//   i_a, i_b      4-bit operands
//   i_cin         carry in
//   i_op          op[2] inverts b, op[1:0] selects AND/OR/ADD/LESS
//   i_less        bit 0 of the result when op[1:0] == 2'b11
//   o_result      slice result
//   o_cout        adder carry out
//   o_overflow    signed overflow of the adder (meaningful for the top slice)
//   o_set         sign bit of the adder output (feeds SLT)
//   o_g, o_p      group generate / propagate for carry-lookahead users
//   o_zero        o_result == 0
module alu_nibble_sequencer_alu4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    input  logic [2:0] i_op,
    input  logic       i_less,
    output logic [3:0] o_result,
    output logic       o_cout,
    output logic       o_overflow,
    output logic       o_set,
    output logic       o_g,
    output logic       o_p,
    output logic       o_zero
);

    logic [3:0] w_b;
    logic [4:0] w_sum;
    logic [3:0] w_gen;
    logic [3:0] w_prop;

    assign w_b    = i_op[2] ? ~i_b : i_b;
    assign w_sum  = {1'b0, i_a} + {1'b0, w_b} + {4'b0000, i_cin};
    assign w_gen  = i_a & w_b;
    assign w_prop = i_a | w_b;

    assign o_cout     = w_sum[4];
    assign o_set      = w_sum[3];
    // Operands of equal sign producing a sum of the other sign.
    assign o_overflow = (i_a[3] == w_b[3]) && (w_sum[3] != i_a[3]);
    assign o_g        = w_gen[3] | (w_prop[3] & w_gen[2]) | (w_prop[3] & w_prop[2] & w_gen[1])
                      | (w_prop[3] & w_prop[2] & w_prop[1] & w_gen[0]);
    assign o_p        = &w_prop;

    always_comb begin
        o_result = 4'b0000;
        case (i_op[1:0])
            2'b00:   o_result = i_a & w_b;
            2'b01:   o_result = i_a | w_b;
            2'b10:   o_result = w_sum[3:0];
            default: o_result = {3'b000, i_less};
        endcase
    end

    assign o_zero = (o_result == 4'b0000);

endmodule

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs WIDTH-bit ALU ops through one 4-bit slice, one nibble per clock,
// least-significant nibble first, with the carry held in a register between nibbles.
// WIDTH must be a multiple of 4 and at least 8.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_req_valid / o_req_ready        request handshake (ready only in IDLE)
//   i_req_op, i_req_a, i_req_b       operation and operands
//   o_rsp_valid / i_rsp_ready        response handshake
//   o_rsp_result                     result
//   o_rsp_cout, o_rsp_overflow       carry / signed overflow of the top nibble (0 for logic ops)
//   o_rsp_zero                       full result is zero
//   o_rsp_err                        request used an illegal op
//   o_busy                           not IDLE
module alu_nibble_sequencer
    import alu_nibble_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [2:0]       i_req_op,
    input  logic [WIDTH-1:0] i_req_a,
    input  logic [WIDTH-1:0] i_req_b,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_cout,
    output logic             o_rsp_overflow,
    output logic             o_rsp_zero,
    output logic             o_rsp_err,
    output logic             o_busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = $clog2(NIB);
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [2:0]       r_op;
    logic [KW-1:0]    r_k;
    logic             r_carry;

    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_cout;
    logic             r_rsp_overflow;
    logic             r_rsp_zero;
    logic             r_rsp_err;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [2:0]       w_slice_op;
    logic [3:0]       w_slice_res;
    logic             w_slice_cout;
    logic             w_slice_ovf;
    logic             w_slice_set;
    logic             w_slice_g_unused;
    logic             w_slice_p_unused;
    logic             w_slice_zero_unused;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_final_res;
    logic             w_arith;

    assign w_nib_a    = 4'(r_a >> {r_k, 2'b00});
    assign w_nib_b    = 4'(r_b >> {r_k, 2'b00});
    // SLT runs as a subtraction; the less-than bit is formed after the top nibble.
    assign w_slice_op = (r_op == OP_SLT) ? OP_SUB : r_op;
    assign w_arith    = op_is_arith(r_op);

    alu_nibble_sequencer_alu4bit u_alu4 (
        .i_a        (w_nib_a),
        .i_b        (w_nib_b),
        .i_cin      (r_carry),
        .i_op       (w_slice_op),
        .i_less     (1'b0),
        .o_result   (w_slice_res),
        .o_cout     (w_slice_cout),
        .o_overflow (w_slice_ovf),
        .o_set      (w_slice_set),
        .o_g        (w_slice_g_unused),
        .o_p        (w_slice_p_unused),
        .o_zero     (w_slice_zero_unused)
    );

    // Accumulated result with the current nibble merged in, so the final nibble is visible
    // on the same edge it is produced.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[{r_k, 2'b00} +: 4] = w_slice_res;
    end

    always_comb begin
        w_final_res = w_acc_next;
        if (r_op == OP_SLT) begin
            w_final_res = {{(WIDTH-1){1'b0}}, w_slice_set ^ w_slice_ovf};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_acc          <= '0;
            r_op           <= OP_AND;
            r_k            <= '0;
            r_carry        <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_cout     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_a     <= i_req_a;
                        r_b     <= i_req_b;
                        r_op    <= i_req_op;
                        r_k     <= '0;
                        r_carry <= i_req_op[2];
                        r_acc   <= '0;
                        if (op_is_legal(i_req_op)) begin
                            r_state <= RUN;
                        end else begin
                            r_state        <= DONE;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_result   <= '0;
                            r_rsp_cout     <= 1'b0;
                            r_rsp_overflow <= 1'b0;
                            r_rsp_zero     <= 1'b1;
                            r_rsp_err      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_slice_cout;
                    r_k     <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_state        <= DONE;
                        r_rsp_valid    <= 1'b1;
                        r_rsp_result   <= w_final_res;
                        r_rsp_cout     <= w_arith & w_slice_cout;
                        r_rsp_overflow <= w_arith & w_slice_ovf;
                        r_rsp_zero     <= (w_final_res == '0);
                        r_rsp_err      <= 1'b0;
                    end
                end
                DONE: begin
                    if (i_rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready    = (r_state == IDLE);
    assign o_busy         = (r_state != IDLE);
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_result   = r_rsp_result;
    assign o_rsp_cout     = r_rsp_cout;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_rsp_zero     = r_rsp_zero;
    assign o_rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed self-checking bench for alu_nibble_sequencer at WIDTH=16.
module tb_alu_nibble_sequencer;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_BAD = 3'b011;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_nibble_sequencer #(
        .WIDTH (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_op       (req_op),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_result   (rsp_result),
        .o_rsp_cout     (rsp_cout),
        .o_rsp_overflow (rsp_overflow),
        .o_rsp_zero     (rsp_zero),
        .o_rsp_err      (rsp_err),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, ".rsp_result"}, 32'(rsp_result), 32'd0);
        check_eq({tag, ".rsp_cout"}, 32'(rsp_cout), 32'd0);
        check_eq({tag, ".rsp_overflow"}, 32'(rsp_overflow), 32'd0);
        check_eq({tag, ".rsp_zero"}, 32'(rsp_zero), 32'd0);
        check_eq({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Issues one request and waits for the response. Latency counts clock edges from the
    // accept edge (inclusive) until rsp_valid is seen.
    task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res, input logic exp_cout,
                          input logic exp_ovf, input logic exp_zero, input logic exp_err,
                          input int exp_lat, input bit release_rsp);
        int  lat;
        bit  seen;
        @(negedge clk);
        check_eq({name, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        lat       = 0;
        seen      = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                req_a     = ~a;
                req_b     = ~b;
            end
            if (rsp_valid) seen = 1'b1;
            else check_eq({name, ".busy"}, 32'(busy), 32'd1);
        end
        check_eq({name, ".seen"}, 32'(seen), 32'd1);
        check_eq({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check_eq({name, ".result"}, 32'(rsp_result), 32'(exp_res));
        check_eq({name, ".cout"}, 32'(rsp_cout), 32'(exp_cout));
        check_eq({name, ".overflow"}, 32'(rsp_overflow), 32'(exp_ovf));
        check_eq({name, ".zero"}, 32'(rsp_zero), 32'(exp_zero));
        check_eq({name, ".err"}, 32'(rsp_err), 32'(exp_err));
        if (release_rsp) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            check_eq({name, ".rel_valid"}, 32'(rsp_valid), 32'd0);
            check_eq({name, ".rel_ready"}, 32'(req_ready), 32'd1);
            check_eq({name, ".rel_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stray;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_AND;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // name, op, a, b, result, cout, ovf, zero, err, latency, release
        run_op("add",      OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 0, 5, 1);
        run_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 0, 5, 1);
        run_op("sub_zero", OP_SUB, 16'h1234, 16'h1234, 16'h0000, 1, 0, 1, 0, 5, 1);
        run_op("slt_neg",  OP_SLT, 16'hFFFE, 16'h0003, 16'h0001, 1, 0, 0, 0, 5, 1);
        run_op("slt_ovf",  OP_SLT, 16'h7FFF, 16'h8000, 16'h0000, 0, 1, 1, 0, 5, 1);
        run_op("and",      OP_AND, 16'hF0F0, 16'h0F0F, 16'h0000, 0, 0, 1, 0, 5, 1);
        run_op("or",       OP_OR,  16'hF0F0, 16'h0F0F, 16'hFFFF, 0, 0, 0, 0, 5, 1);
        run_op("illegal",  OP_BAD, 16'h1234, 16'h5678, 16'h0000, 0, 0, 1, 1, 1, 1);

        // Backpressure: response held while new requests are offered and dropped.
        run_op("bp", OP_ADD, 16'h1111, 16'h2222, 16'h3333, 0, 0, 0, 0, 5, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = (i % 2 == 0);
            req_op    = OP_OR;
            req_a     = 16'hFFFF;
            req_b     = 16'h0000;
            @(posedge clk);
            #1;
            check_eq($sformatf("bp.hold%0d.valid", i), 32'(rsp_valid), 32'd1);
            check_eq($sformatf("bp.hold%0d.result", i), 32'(rsp_result), 32'h3333);
            check_eq($sformatf("bp.hold%0d.req_ready", i), 32'(req_ready), 32'd0);
            check_eq($sformatf("bp.hold%0d.busy", i), 32'(busy), 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("bp.release.valid", 32'(rsp_valid), 32'd0);
        check_eq("bp.release.req_ready", 32'(req_ready), 32'd1);
        stray = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) stray = 1'b1;
        end
        check_eq("bp.dropped", 32'(stray), 32'd0);

        // Async reset during the second RUN cycle of an ADD.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_a     = 16'h00FF;
        req_b     = 16'h0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        check_eq("rst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) stray = 1'b1;
        end
        check_eq("rst.no_response", 32'(stray), 32'd0);
        run_op("add_after_rst", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 0, 5, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
